// File: rtl/jam_pkg.sv
// Shared constants and FSM encoding for the cost-lookup arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default requester count, worker/job index width, cost width,
// and the IDLE/BURST state enumeration.
package jam_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int IDX_W       = 3;
  localparam int COST_W      = 7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/jam_rr_pick.sv
// Round-robin picker: first requester at or after the pointer, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
// Ports:
//   req_i  [N]   request vector
//   rr_i   [PW]  priority pointer (index of highest-priority requester)
//   pick_o [N]   one-hot winner, all zeros when no request
//   any_o        at least one request present
module jam_rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] rr_i,
  output logic [N-1:0]  pick_o,
  output logic          any_o
);

  always_comb begin
    logic          found;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    pick_o = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      // One extra bit so pointer + offset can exceed N before wrapping.
      sum = {1'b0, rr_i} + (PW + 1)'(i);
      if (sum >= (PW + 1)'(N)) begin
        sum = sum - (PW + 1)'(N);
      end
      idx = sum[PW-1:0];
      if (!found && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/jam_cost_arb.sv
// Burst arbiter sharing one worker/job cost-table port among NUM_REQ requesters.
// Latency: grant 1 cycle after request in IDLE; response 2 cycles after accept.
// Backpressure: owner stalls by dropping req; grant is held across stalls.
// Ports:
//   CLK, RST          clock (rising edge), async active-high reset
//   req/req_last      per-requester request and end-of-burst marker
//   req_w/req_j       per-requester worker/job index, IDX_W bits each
//   gnt               registered one-hot grant, constant for a whole burst
//   W/J               registered index pair driven to the cost table
//   Cost              table output, valid the cycle after W/J change
//   rsp_valid/rsp_cost registered one-hot response strobe and cost
//   err_to            one-cycle idle-owner timeout pulse
// Optional feature: define JAM_ARB_TIMEOUT_EN to release a grant whose owner
// stays idle for TO_CYC consecutive cycles; otherwise err_to is tied low and
// a grant is held until the owner's last lookup.
module jam_cost_arb
  import jam_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int TO_CYC  = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] req_w,
  input  logic [NUM_REQ*IDX_W-1:0] req_j,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [IDX_W-1:0]         W,
  output logic [IDX_W-1:0]         J,
  input  logic [COST_W-1:0]        Cost,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [COST_W-1:0]        rsp_cost,
  output logic                     err_to
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // TO_CYC must be at least 1; it is only consumed by the timeout build.
  if (TO_CYC < 1) begin : g_to_cyc_invalid
  end

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [IDX_W-1:0]     w_q, w_d, j_q, j_d;
  logic                 acc_q;
  logic [NUM_REQ-1:0]   acc_oh_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [COST_W-1:0]    rsp_cost_q;

  logic [NUM_REQ-1:0]   pick_oh;
  logic                 pick_any;
  logic [PW-1:0]        pick_idx;
  logic                 accept;
  logic [PW-1:0]        rr_after;

  jam_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req_i  (req),
    .rr_i   (rr_q),
    .pick_o (pick_oh),
    .any_o  (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        pick_idx = PW'(i);
      end
    end
  end

  // gnt_q is zero outside BURST, so this is only ever the owner's handshake.
  assign accept   = |(req & gnt_q);
  assign rr_after = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef JAM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_q;
  logic          to_fire;

  // Fires at the end of the TO_CYC-th consecutive owner-idle BURST cycle.
  assign to_fire = (state_q == ST_BURST) && !accept && (to_cnt_q == TW'(TO_CYC - 1));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q != ST_BURST || accept || to_fire) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= to_fire;
    end
  end

  assign err_to = err_q;
`else
  assign err_to = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    w_d     = w_q;
    j_d     = j_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_BURST;
          gnt_d   = pick_oh;
          owner_d = pick_idx;
        end
      end
      ST_BURST: begin
        if (accept) begin
          w_d = req_w[owner_q*IDX_W +: IDX_W];
          j_d = req_j[owner_q*IDX_W +: IDX_W];
          if (req_last[owner_q]) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            rr_d    = rr_after;
          end
        end
`ifdef JAM_ARB_TIMEOUT_EN
        else if (to_fire) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          rr_d    = rr_after;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // acc_q/acc_oh_q carry the accept across the table-read cycle; Cost is
  // captured at the end of that cycle and presented one cycle later.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      rr_q        <= '0;
      owner_q     <= '0;
      w_q         <= '0;
      j_q         <= '0;
      acc_q       <= 1'b0;
      acc_oh_q    <= '0;
      rsp_valid_q <= '0;
      rsp_cost_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      w_q         <= w_d;
      j_q         <= j_d;
      acc_q       <= accept;
      if (accept) begin
        acc_oh_q <= gnt_q;
      end
      rsp_valid_q <= acc_q ? acc_oh_q : '0;
      if (acc_q) begin
        rsp_cost_q <= Cost;
      end
    end
  end

  assign gnt       = gnt_q;
  assign W         = w_q;
  assign J         = j_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_cost  = rsp_cost_q;

endmodule

// File: doc/jam_cost_arb.md
JAM_COST_ARB -- requirements
Module: jam_cost_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the cost-lookup port.
REQ-002 SHALL have parameter TO_CYC, default 16, idle-owner timeout in cycles (used only with the timeout feature of REQ-026).
REQ-003 SHALL have port CLK  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester lookup request.
REQ-006 SHALL have port req_w  input  NUM_REQ*3  per-requester worker index.
REQ-007 SHALL have port req_j  input  NUM_REQ*3  per-requester job index.
REQ-008 SHALL have port req_last  input  NUM_REQ  marks the final lookup of a burst.
REQ-009 SHALL have port gnt  output  NUM_REQ  registered one-hot grant.
REQ-010 SHALL have port W  output  3  registered worker index to the cost table.
REQ-011 SHALL have port J  output  3  registered job index to the cost table.
REQ-012 SHALL have port Cost  input  7  cost value, valid in the cycle after W/J update.
REQ-013 SHALL have port rsp_valid  output  NUM_REQ  registered one-hot response strobe.
REQ-014 SHALL have port rsp_cost  output  7  registered cost returned with rsp_valid.
REQ-015 SHALL have port err_to  output  1  one-cycle timeout pulse; tied 0 without the timeout feature.

Function
REQ-016 SHALL implement FSM IDLE -> BURST -> IDLE; BURST holds one owner for a whole burst (e.g. the 8 lookups of one permutation).
REQ-017 In IDLE with any req high in cycle t, SHALL pick the owner round-robin, starting at pointer rr, and assert gnt[owner] from cycle t+1.
REQ-018 In BURST, SHALL ignore req from non-owners; gnt SHALL stay constant.
REQ-019 An accept SHALL occur in cycle a when req[owner] and gnt[owner] are both high; W/J SHALL take req_w/req_j[owner] in a+1.
REQ-020 SHALL sample Cost at the end of a+1 and present rsp_cost with rsp_valid[owner] high in a+2; latency 2; back-to-back accepts every cycle supported.
REQ-021 An accept with req_last high SHALL drop gnt in a+1 (FSM IDLE), set rr = owner+1 mod NUM_REQ, and still deliver the last response in a+2; the next grant is visible no earlier than a+2.
REQ-022 req low from the owner in BURST SHALL be treated as a stall: no accept, W/J held, grant kept.
REQ-023 req_last on the first accept SHALL form a legal single-lookup burst.
REQ-024 W/J SHALL hold their last value when no accept occurs.

Reset
REQ-025 On RST high: FSM IDLE, rr=0, gnt=0, W=0, J=0, rsp_valid=0, rsp_cost=0, err_to=0, timeout counter 0; in-flight responses are dropped; effect is immediate and independent of CLK.

Configuration
REQ-026 With JAM_ARB_TIMEOUT_EN defined: if the owner has req low for TO_CYC consecutive BURST cycles, the block SHALL drop gnt, return to IDLE, set rr = owner+1, and pulse err_to for one cycle; any accept resets the count. Without the macro: no counter, err_to constant 0, and a grant is held indefinitely.

Structure
REQ-027 Package jam_pkg SHALL hold NUM_REQ default, index width (3), cost width (7), and the FSM state enumeration.
REQ-028 The round-robin pick SHALL be a combinational sub-module jam_rr_pick (inputs req vector and rr pointer; outputs one-hot pick and any-valid).

Verification
REQ-029 After reset, req=4'b1111 -> gnt=4'b0001 in the next cycle; after requester 0's burst, gnt=4'b0010.
REQ-030 Requester 2 bursts 8 lookups (W=2, J=0..7, table Cost=10+J) -> rsp_valid[2] for 8 consecutive cycles, rsp_cost 10..17, first response 2 cycles after the first accept.
REQ-031 Owner 1 drops req for 3 cycles mid-burst while req[3] is high -> gnt stays 4'b0010, no rsp_valid in the gap, W/J held.
REQ-032 req_last on the first accept of requester 3 -> exactly one response; gnt=0 the next cycle; rr wraps so requester 0 gets the next grant.
REQ-033 RST asserted while gnt=4'b0100 with 2 responses in flight -> all outputs 0 immediately, no rsp_valid afterwards, next grant goes to requester 0.
REQ-034 (JAM_ARB_TIMEOUT_EN) Owner 0 holds req low for 16 cycles -> err_to pulses once, gnt drops, a waiting req[1] is granted.
